id_regfile_sb: RTL and testbench
================================

# id_regfile_sb

Parametrised decode-stage integer register file with a per-register pending-write scoreboard. It provides `NRD` combinational read ports with optional same-cycle write-through bypass and one synchronous writeback port. Per-register saturating counters track outstanding writes reserved at issue, so decode can stall on read-after-write hazards. It sits between the decoder (read addresses, issue reservations) and the writeback/forwarding path, and drives source operands into the ID/EX register.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥2.
- `NRD`, 2, number of read ports, 1..4.
- `PEND_W`, 2, pending-counter width; at most 2^`PEND_W`−1 outstanding writes per register.
- `AW`, derived, equals $clog2(`NREGS`).

- `clk` in 1 — clock, rising-edge.
- `rst` in 1 — reset; synchronous, active-high.
- `rs_addr` in `NRD`*`AW` — read addresses; port i occupies bits [i*`AW` +: `AW`].
- `rdata` out `NRD`*`XLEN` — read data, port i at [i*`XLEN` +: `XLEN`].
- `rs_busy` out `NRD` — port i source has an outstanding write.
- `rsv_valid` in 1 — issue reserves destination `rsv_rd`.
- `rsv_rd` in `AW` — destination to reserve.
- `rsv_ready` out 1 — a reservation can be accepted this cycle.
- `wb_valid` in 1 — writeback strobe.
- `wb_rd` in `AW` — writeback destination.
- `wb_data` in `XLEN` — writeback value.
- `flush` in 1 — pipeline flush; discards all reservations.

## Operation
- Register 0 reads 0 at all times. Writes to it are dropped. Reservations of it are accepted but never counted.
- Read port i: `rdata` = regs[`rs_addr`_i], or `wb_data` when bypass applies (see Configuration). Ports are independent; any address aliasing between ports is legal.
- Each register has a counter `pend[r]`.
  - An accepted reservation (`rsv_valid` && `rsv_ready`, `rsv_rd`≠0) increments `pend[rsv_rd]`.
  - `wb_valid` with `wb_rd`≠0 writes `wb_data` and decrements `pend[wb_rd]`. The decrement saturates at 0 (late writeback after a flush).
  - A reservation and a writeback to the same register in the same cycle leave the count unchanged.
- `rsv_ready` = !rst && !flush && (`rsv_rd`==0 || `pend[rsv_rd]` != max || (`wb_valid` && `wb_rd`==`rsv_rd`)).
- `flush`: on the next edge, all `pend` are cleared and any same-cycle reservation is dropped. A same-cycle writeback still writes the array.
- `rs_busy`_i = `pend[rs_addr_i]` != 0, with two exceptions:
  - `rs_addr_i` == 0 gives 0.
  - Under bypass, if a writeback hits that address and `pend` == 1, `rs_busy`_i is 0, because the final outstanding value is on the bus.

## Timing
- While `rst` is high, all outputs are forced:
  - `rdata` = 0
  - `rs_busy` = 0
  - `rsv_ready` = 0
- The first edge with `rst` high clears all registers and counters. Reset wins over write, reserve and flush.
- Reset asserted mid-operation discards all pending state. Writebacks in flight after release update the array; their decrements saturate at 0.
- Read latency is 0 cycles (combinational).
- Write takes effect at the rising edge. Without bypass, the written value is visible from the next cycle.
- Counter updates take effect at the edge; `rs_busy` reflects them in the following cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose address matches an active `wb_rd` (≠0) returns `wb_data` in the same cycle.
  - `rs_busy` clears in that same cycle per the rule above.
- Undefined:
  - Reads return stored contents only.
  - `rs_busy` ignores the current writeback, so a consumer stalls one extra cycle.

## Structure
- Package `regfile_pkg`:
  - defaults for `XLEN` and `NREGS`
  - `AW` helper
  - typedefs for the register address and the data word
- Sub-module `regfile_pend_ctr`: one saturating up/down counter with inc/dec/clear/max flag, instantiated `NREGS`−1 times through a generate loop.

## Test plan
- Reset: drive `rst` for 2 cycles, read x1..x31 → every `rdata` = 0, `rs_busy` = 0.
- Write/read: wb x5 = 0xDEADBEEF, read x5 next cycle on both ports → 0xDEADBEEF. A wb to x0 of 0x1234 → x0 still reads 0.
- Bypass: wb x7 = 0xA5A5A5A5 while reading x7 in the same cycle → same-cycle 0xA5A5A5A5 with the macro, old value 0 without it.
- Scoreboard:
  - reserve x3 twice (`pend` = 2), read x3 → `rs_busy` = 1
  - one wb x3 → still busy
  - second wb x3 → busy clears; same cycle with bypass, next cycle without
- Saturation: with `PEND_W` = 2, reserve x9 3 times → `rsv_ready` = 0 for x9. A reserve and a wb to x9 in the same cycle → `rsv_ready` = 1, and the count stays at 3.
- Flush: reserve x4 and x6, then assert `flush` together with a reserve of x8 → all `rs_busy` = 0 next cycle, x8 not busy. A later wb x4 = 0x11 writes the value, and `pend` stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and word typedefs for the decode-stage register file.
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int AW_DEF = addr_w(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] data_t;
endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating up/down pending-write counter for one architectural register.
module regfile_pend_ctr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         is_max
);
   assign is_max = (count == '1);

   // Simultaneous inc and dec cancel; dec at zero is a late writeback and is ignored.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && !dec && !is_max) begin
         count <= count + 1'b1;
      end else if (dec && !inc && count != '0) begin
         count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward the current writeback to same-cycle reads.
module id_regfile_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREGS  = NREGS_DEF,
   parameter  int NRD    = 2,
   parameter  int PEND_W = 2,
   localparam int AW     = addr_w(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rs_addr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]    rs_busy,
   input  logic              rsv_valid,
   input  logic [AW-1:0]     rsv_rd,
   output logic              rsv_ready,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush
);
   logic [XLEN-1:0]   regs     [NREGS];
   logic [PEND_W-1:0] pend     [NREGS];
   logic              pend_max [NREGS];
   logic              wb_hit;
   logic              rsv_fire;

   assign wb_hit   = wb_valid && (wb_rd != '0);
   assign rsv_fire = rsv_valid && rsv_ready && (rsv_rd != '0);

   // A full counter can still take a reservation if a writeback to it retires this cycle.
   assign rsv_ready = !rst && !flush &&
                      ((rsv_rd == '0) || !pend_max[rsv_rd] || (wb_valid && wb_rd == rsv_rd));

   // x0 is never written, so regs[0] stays at its reset value of zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (wb_hit) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign pend[0]     = '0;
   assign pend_max[0] = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_pend
      regfile_pend_ctr #(.W(PEND_W)) u_ctr (
         .clk    (clk),
         .rst    (rst),
         .clr    (flush),
         .inc    (rsv_fire && (rsv_rd == AW'(r))),
         .dec    (wb_hit && (wb_rd == AW'(r))),
         .count  (pend[r]),
         .is_max (pend_max[r])
      );
   end

   for (genvar i = 0; i < NRD; i++) begin : g_port
      logic [AW-1:0] addr;
      logic          byp_hit;

      assign addr = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign byp_hit = wb_hit && (wb_rd == addr);
`else
      assign byp_hit = 1'b0;
`endif
      assign rdata[i*XLEN +: XLEN] = rst ? '0 : (byp_hit ? wb_data : regs[addr]);
      // The last outstanding value on the writeback bus releases the consumer now.
      assign rs_busy[i] = !rst && (addr != '0) && (pend[addr] != '0) &&
                          !(byp_hit && pend[addr] == PEND_W'(1));
   end
endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: behavioural model checked every cycle plus literal spot checks.
module tb_id_regfile_sb;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NRD    = 2;
   localparam int PEND_W = 2;
   localparam int AW     = 5;
   localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rs_addr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]    rs_busy;
   logic              rsv_valid;
   logic [AW-1:0]     rsv_rd;
   logic              rsv_ready;
   logic              wb_valid;
   logic [AW-1:0]     wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              flush;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   id_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PEND_W(PEND_W)) dut (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rdata(rdata), .rs_busy(rs_busy),
      .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
   );

   // behavioural model: architectural values and outstanding-write counts
   logic [XLEN-1:0] m_regs [NREGS];
   int              m_pend [NREGS];

   initial begin
      for (int r = 0; r < NREGS; r++) begin
         m_regs[r] = '0;
         m_pend[r] = 0;
      end
   end

   function automatic logic byp_hits(input logic [AW-1:0] a);
      return BYP && wb_valid && (wb_rd == a) && (a != 0);
   endfunction

   function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
      if (rst || a == 0) return '0;
      if (byp_hits(a)) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (rst || a == 0) return 1'b0;
      if (byp_hits(a) && m_pend[a] == 1) return 1'b0;
      return m_pend[a] != 0;
   endfunction

   function automatic logic exp_ready();
      if (rst || flush) return 1'b0;
      return (rsv_rd == 0) || (m_pend[rsv_rd] < PMAX) || (wb_valid && wb_rd == rsv_rd);
   endfunction

   always @(posedge clk) begin
      logic acc;
      acc = exp_ready() && rsv_valid && (rsv_rd != 0);
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
         end
      end else begin
         if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
         if (flush) begin
            for (int r = 0; r < NREGS; r++) m_pend[r] = 0;
         end else if (!(acc && wb_valid && wb_rd == rsv_rd)) begin
            if (acc) m_pend[rsv_rd] = m_pend[rsv_rd] + 1;
            if (wb_valid && wb_rd != 0 && m_pend[wb_rd] > 0) m_pend[wb_rd] = m_pend[wb_rd] - 1;
         end
      end
   end

   // scoreboard check task
   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      for (int i = 0; i < NRD; i++) begin
         check($sformatf("model_rdata%0d", i), rdata[i*XLEN +: XLEN], exp_rdata(rs_addr[i*AW +: AW]));
         check($sformatf("model_busy%0d", i), XLEN'(rs_busy[i]), XLEN'(exp_busy(rs_addr[i*AW +: AW])));
      end
      check("model_ready", XLEN'(rsv_ready), XLEN'(exp_ready()));
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rsv_valid = 1'b0; rsv_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
   endtask

   task automatic rd(input int a0, input int a1);
      rs_addr[0 +: AW]  = AW'(a0);
      rs_addr[AW +: AW] = AW'(a1);
   endtask

   task automatic wb(input int r, input logic [XLEN-1:0] d);
      wb_valid = 1'b1; wb_rd = AW'(r); wb_data = d;
   endtask

   task automatic rsv(input int r);
      rsv_valid = 1'b1; rsv_rd = AW'(r);
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b1; rs_addr = '0; idle();
      rd(5, 9);
      cyc();
      settle();
      check("reset_rdata0", rdata[0 +: XLEN], 32'h0);
      check("reset_busy", XLEN'(rs_busy), 32'h0);
      check("reset_ready", XLEN'(rsv_ready), 32'h0);
      cyc();
      rst = 1'b0;
      for (int a = 1; a < NREGS; a++) begin
         rd(a, NREGS - a);
         cyc();
      end
      settle();
      check("post_reset_x1", rdata[XLEN +: XLEN], 32'h0);

      wb(5, 32'hDEADBEEF); rd(5, 5);
      cyc(); idle();
      settle();
      check("wr_x5_p0", rdata[0 +: XLEN], 32'hDEADBEEF);
      check("wr_x5_p1", rdata[XLEN +: XLEN], 32'hDEADBEEF);
      wb(0, 32'h1234); rd(0, 0);
      cyc(); idle();
      settle();
      check("x0_zero", rdata[0 +: XLEN], 32'h0);

      rd(7, 5); wb(7, 32'hA5A5A5A5);
      settle();
      check("bypass_x7", rdata[0 +: XLEN], BYP ? 32'hA5A5A5A5 : 32'h0);
      cyc(); idle();
      settle();
      check("after_wr_x7", rdata[0 +: XLEN], 32'hA5A5A5A5);

      rsv(0);
      settle();
      check("rsv_x0_ready", XLEN'(rsv_ready), 32'h1);
      cyc();
      rsv(3); rd(3, 0); cyc(); cyc(); idle();
      settle();
      check("x3_busy_pend2", XLEN'(rs_busy), 32'h1);
      wb(3, 32'h33); cyc(); idle();
      settle();
      check("x3_busy_pend1", XLEN'(rs_busy), 32'h1);
      wb(3, 32'h333);
      settle();
      check("x3_busy_final_wb", XLEN'(rs_busy), BYP ? 32'h0 : 32'h1);
      cyc(); idle();
      settle();
      check("x3_clear", XLEN'(rs_busy), 32'h0);
      check("x3_value", rdata[0 +: XLEN], 32'h333);

      rsv(9); rd(9, 9); cyc(); cyc(); cyc();
      settle();
      check("x9_full_ready", XLEN'(rsv_ready), 32'h0);
      wb(9, 32'h99);
      settle();
      check("x9_full_wb_ready", XLEN'(rsv_ready), 32'h1);
      cyc(); idle(); rsv_rd = AW'(9);
      settle();
      check("x9_still_full", XLEN'(rsv_ready), 32'h0);
      check("x9_busy", XLEN'(rs_busy), 32'h3);
      cyc();

      rsv(4); cyc(); rsv(6); cyc();
      rsv(8); flush = 1'b1;
      settle();
      check("flush_ready", XLEN'(rsv_ready), 32'h0);
      cyc(); idle(); rd(4, 6);
      settle();
      check("flush_busy_46", XLEN'(rs_busy), 32'h0);
      rd(8, 9); cyc();
      settle();
      check("flush_busy_89", XLEN'(rs_busy), 32'h0);
      wb(4, 32'h11); rd(4, 4); cyc(); idle();
      settle();
      check("late_wb_x4", rdata[0 +: XLEN], 32'h11);
      check("late_wb_busy", XLEN'(rs_busy), 32'h0);

      rsv(10); rd(10, 10); cyc(); idle();
      rst = 1'b1; cyc(); rst = 1'b0;
      settle();
      check("midrst_busy", XLEN'(rs_busy), 32'h0);
      check("midrst_data", rdata[0 +: XLEN], 32'h0);

      for (int k = 0; k < 300; k++) begin
         idle();
         rd($urandom_range(0, 7), $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) rsv($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) wb($urandom_range(0, 7), XLEN'($urandom));
         flush = ($urandom_range(0, 29) == 0);
         rst   = ($urandom_range(0, 79) == 0);
         cyc();
      end
      rst = 1'b0; idle();
      cyc();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
